// File: rtl/mips_pkg.sv
// Shared definitions for the I/D cache memory arbiter.
// Holds the default memory block geometry, the arbiter state encoding,
// the grant-history encoding and the D-side command decode helper.
package mips_pkg;

    // Default memory block geometry (block address / block data widths).
    localparam int DEF_ADDR_W = 28;
    localparam int DEF_DATA_W = 128;

    // Arbiter FSM states: one BUSY and one DONE state per requester.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_BUSY = 3'd1,
        D_BUSY = 3'd2,
        I_DONE = 3'd3,
        D_DONE = 3'd4
    } arb_state_t;

    // Which requester was served most recently.
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Memory command as presented on the shared port.
    typedef struct packed {
        logic rd;
        logic wr;
    } mem_cmd_t;

    // D-cache command decode: a write takes precedence when the D-cache
    // raises read and write together, so the two strobes never overlap.
    function automatic mem_cmd_t dc_cmd(input logic rd, input logic wr);
        mem_cmd_t c;
        c.wr = wr;
        c.rd = rd & ~wr;
        return c;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and shared memory port signals.
// Ports: ic_* (I-cache read request/response), dc_* (D-cache read/write
// request/response), mem_* (registered shared memory port and its response).
interface mem_arbiter_if
    import mips_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    // I-cache side: request held until ic_ready pulses.
    logic              ic_read;
    logic [ADDR_W-1:0] ic_addr;
    logic [DATA_W-1:0] ic_rdata;
    logic              ic_ready;

    // D-cache side: request held until dc_ready pulses.
    logic              dc_read;
    logic              dc_write;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic [DATA_W-1:0] dc_rdata;
    logic              dc_ready;

    // Shared memory port.
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    // Arbiter view: it serves both caches and masters the memory port.
    modport master (
        input  ic_read, ic_addr,
        input  dc_read, dc_write, dc_addr, dc_wdata,
        input  mem_rdata, mem_ready,
        output ic_rdata, ic_ready,
        output dc_rdata, dc_ready,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    // Environment view: caches and memory surrounding the arbiter.
    modport slave (
        output ic_read, ic_addr,
        output dc_read, dc_write, dc_addr, dc_wdata,
        output mem_rdata, mem_ready,
        input  ic_rdata, ic_ready,
        input  dc_rdata, dc_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arb_pick2.sv
// Two-way round-robin pick between the I-cache and D-cache requests.
// Latency: purely combinational, result used in the same cycle.
// Backpressure: none; the caller only samples grant_d while idle.
// Ports: req_i / req_d (pending requests), last_grant (most recent winner),
// grant_d (1 = D-cache wins, 0 = I-cache wins or nobody requests D).
module arb_pick2
    import mips_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  grant_t last_grant,
    output logic   grant_d
);

    // D wins when it is alone, or on a conflict when I was served last.
    assign grant_d = req_d && (!req_i || (last_grant == GRANT_I));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between an I-cache and a D-cache, round-robin on conflicts.
// Latency: mem_* registered 1 cycle after request; ready pulses 1 cycle after mem_ready.
// Backpressure: requests held until ready; one transaction in flight, mem_* held until mem_ready.
// Ports: clk, rst (synchronous, active-high), bus (mem_arbiter_if.master:
// ic_* / dc_* cache request and response, mem_* shared memory port).
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    grant_t            last_grant;

    logic              req_i;
    logic              req_d;
    logic              grant_d;
    mem_cmd_t          d_cmd;

    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] ic_rdata_q;
    logic [DATA_W-1:0] dc_rdata_q;
    logic              ic_ready_c;
    logic              dc_ready_c;

    assign req_i = bus.ic_read;
    assign req_d = bus.dc_read | bus.dc_write;
    assign d_cmd = dc_cmd(bus.dc_read, bus.dc_write);

    arb_pick2 u_pick (
        .req_i      (req_i),
        .req_d      (req_d),
        .last_grant (last_grant),
        .grant_d    (grant_d)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and ready pulses. Ready is decoded from the DONE
    // states, which last exactly one cycle, so each pulse is one cycle
    // wide and the two readies are mutually exclusive by construction.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        ic_ready_c = 1'b0;
        dc_ready_c = 1'b0;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = D_BUSY;
                end else if (req_i) begin
                    state_nxt = I_BUSY;
                end
            end
            I_BUSY: begin
                if (bus.mem_ready) begin
                    state_nxt = I_DONE;
                end
            end
            D_BUSY: begin
                if (bus.mem_ready) begin
                    state_nxt = D_DONE;
                end
            end
            I_DONE: begin
                ic_ready_c = 1'b1;
                state_nxt  = IDLE;
            end
            D_DONE: begin
                dc_ready_c = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: memory request registers, per-requester read data and
    // grant history. mem_ready is only looked at in the BUSY states, so
    // a stray or late response in IDLE/DONE has no effect.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= GRANT_I;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_read_q  <= d_cmd.rd;
                        mem_write_q <= d_cmd.wr;
                        mem_addr_q  <= bus.dc_addr;
                        mem_wdata_q <= bus.dc_wdata;
                    end else if (req_i) begin
                        mem_read_q  <= 1'b1;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= bus.ic_addr;
                        mem_wdata_q <= '0;
                    end
                end
                I_BUSY: begin
                    if (bus.mem_ready) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        ic_rdata_q  <= bus.mem_rdata;
                    end
                end
                D_BUSY: begin
                    if (bus.mem_ready) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        // A write completion carries no data for the D-cache.
                        if (mem_read_q) begin
                            dc_rdata_q <= bus.mem_rdata;
                        end
                    end
                end
                I_DONE: begin
                    last_grant <= GRANT_I;
                end
                D_DONE: begin
                    last_grant <= GRANT_D;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.ic_rdata  = ic_rdata_q;
    assign bus.dc_rdata  = dc_rdata_q;
    assign bus.ic_ready  = ic_ready_c;
    assign bus.dc_ready  = dc_ready_c;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, memory block address width.
REQ-002 SHALL have parameter DATA_W, default 128, memory block data width.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports ic_read  in  1 / ic_addr  in  ADDR_W  I-cache block read request, held until ic_ready.
REQ-006 SHALL have ports ic_rdata  out  DATA_W / ic_ready  out  1  I-cache return data and one-cycle completion pulse.
REQ-007 SHALL have ports dc_read  in  1 / dc_write  in  1 / dc_addr  in  ADDR_W / dc_wdata  in  DATA_W  D-cache request, held until dc_ready.
REQ-008 SHALL have ports dc_rdata  out  DATA_W / dc_ready  out  1  D-cache return data and one-cycle completion pulse.
REQ-009 SHALL have ports mem_read  out  1 / mem_write  out  1 / mem_addr  out  ADDR_W / mem_wdata  out  DATA_W  shared memory port, all registered.
REQ-010 SHALL have ports mem_rdata  in  DATA_W / mem_ready  in  1  memory return data and completion.

Function
REQ-011 SHALL implement FSM states IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE.
REQ-012 IDLE: I-only request -> I_BUSY; D-only request -> D_BUSY; none -> stay IDLE.
REQ-013 IDLE, both requesting: grant the requester not granted last (last_grant flag); after reset last_grant=I, so the first conflict goes to D.
REQ-014 On grant, SHALL register mem_addr, mem_wdata, mem_read/mem_write on that edge; memory sees the request the cycle after the request is sampled.
REQ-015 D grant: dc_write=1 -> mem_write=1, mem_read=0 (write wins if both dc_read and dc_write are high); else mem_read=1.
REQ-016 I grant SHALL always drive mem_read=1, mem_write=0, mem_wdata=0.
REQ-017 x_BUSY SHALL hold mem_* stable until mem_ready=1, then clear mem_read/mem_write, capture mem_rdata into the granted requester's rdata register, and go to x_DONE.
REQ-018 x_DONE SHALL assert only the granted ready for exactly one cycle, update last_grant, and return to IDLE.
REQ-019 ic_rdata/dc_rdata SHALL hold their last captured value until the next completion for that requester; a write completion leaves dc_rdata unchanged.
REQ-020 Minimum turnaround: request sampled cycle 0, mem_read high cycles 1..k, mem_ready at k, ready pulse at k+1, next grant evaluated at k+2.
REQ-021 Request deassertion during x_BUSY SHALL NOT abort the transaction; ready still pulses.
REQ-022 mem_ready in IDLE or x_DONE SHALL be ignored.
REQ-023 ic_ready and dc_ready SHALL never be high in the same cycle; mem_read and mem_write SHALL never be high together.

Reset
REQ-024 rst=1 SHALL force IDLE, last_grant=I, and all outputs (mem_*, ic_*, dc_*) to 0 on the next edge, including mid-transaction; any in-flight memory result is discarded.

Structure
REQ-025 Package mips_pkg SHALL hold ADDR_W/DATA_W defaults and the arb_state_t enumeration.
REQ-026 Grant selection SHALL be a sub-module arb_pick2 (inputs: req_i, req_d, last_grant; output: grant_d).

Verification
REQ-027 I-only: ic_read=1, ic_addr=0x0000010, memory latency 3 with rdata=0xA5..A5 -> mem_read cycles 1-3, ic_ready cycle 4, ic_rdata=0xA5..A5.
REQ-028 D write: dc_write=1, dc_addr=0x00000FF, dc_wdata=0x1234 -> mem_write=1 with that addr/data until mem_ready; dc_ready one pulse; dc_rdata unchanged.
REQ-029 Conflict after reset: ic_read and dc_read both held -> D served first, then I; repeated conflicts alternate D,I,D,I.
REQ-030 dc_read=dc_write=1 -> mem_write=1, mem_read=0.
REQ-031 rst pulse during I_BUSY -> next cycle all outputs 0, state IDLE; late mem_ready produces no ready pulse.
REQ-032 Spurious mem_ready in IDLE -> no ready pulse, no rdata change.
